sha256_msg_padder: RTL
======================

// Module: sha256_msg_padder
// PURPOSE
//  Upstream feeder for the SHA-256 hash core. Reads an L-word message from word-addressed
//  memory and emits the FIPS 180-4 padded stream one 32-bit word per handshake:
//  message words, 0x80000000, zero fill, then the 64-bit bit-length, in 16-word blocks.
//  The hash core no longer needs to know L at elaboration time.
// PARAMETERS
//  MAX_WORDS  1024  largest accepted msg_len in words; larger lengths are rejected
// PORTS
//  clk            in   1   single clock; memory runs on it (mem_clk = clk)
//  reset          in   1   synchronous, active-high reset
//  start          in   1   begin a message; sampled only in IDLE
//  message_addr   in  16   word address of message word 0; latched on start
//  msg_len        in  16   message length L in 32-bit words; latched on start
//  mem_clk        out  1   = clk
//  mem_we         out  1   constant 0 (read-only master)
//  mem_addr       out 16   read address; memory read latency is 1 cycle
//  mem_read_data  in  32   read data, valid the cycle after mem_addr is presented
//  out_valid      out  1   out_word holds a valid stream word
//  out_ready      in   1   consumer accepts; transfer when out_valid & out_ready
//  out_word       out 32   padded stream word
//  out_blk_last   out  1   qualifies out_word: last word of a 16-word block
//  out_last       out  1   qualifies out_word: final word of the message
//  busy           out  1   high in any state other than IDLE
//  done           out  1   one-cycle pulse the cycle after the out_last transfer
//  len_err        out  1   one-cycle pulse when start arrives with msg_len > MAX_WORDS
// BEHAVIOUR
//  Reset: state=IDLE; out_valid, busy, done, len_err, mem_we=0; mem_addr=0; word index w=0.
//  Geometry: nblk = (L+18)>>4 (=ceil((L+3)/16)); T = 16*nblk words; w counts 0..T-1.
//  Word w: w<L -> mem[message_addr+w]; w==L -> 32'h80000000; L<w<T-2 -> 0;
//          w==T-2 -> L>>27 (length bits 63:32); w==T-1 -> {L[26:0],5'b0} (length bits 31:0).
//  Address arithmetic is modulo 2^16 (wraps); bit length is L*32 with no truncation.
//  FSM:
//   IDLE : start & L<=MAX_WORDS -> latch addr/L, w=0, go REQ (if L==0 go PAD).
//          start & L>MAX_WORDS -> pulse len_err, stay IDLE. No start -> stay.
//   REQ  : drive mem_addr = message_addr+w for one cycle -> WAIT.
//   WAIT : capture mem_read_data into out_word -> SEND.
//   SEND : out_valid=1, out_word held stable until the transfer. On transfer: w++;
//          if new w<L -> REQ, else -> PAD. Message words cost 3 cycles each at out_ready=1.
//   PAD  : out_valid=1, out_word per padding rule; one word per cycle while out_ready=1.
//          Transfer with w==T-1 -> DONE.
//   DONE : done=1 for one cycle, out_valid=0 -> IDLE.
//  Timing: start sampled at edge N -> mem_addr valid cycle N+1, out_valid first high N+3.
//  out_valid never drops and out_word/out_blk_last/out_last never change until transferred.
//  out_blk_last = (w[3:0]==15); out_last = (w==T-1); both 0 whenever out_valid=0.
//  start while busy: ignored, no effect on the stream in progress.
//  reset mid-stream: immediate return to IDLE next edge; partial stream abandoned, no done.
//  L==MAX_WORDS accepted; L==0 yields one block of pure padding.
// TESTING
//  1 L=20, mem[0x0000+i]=0x1000+i, ready=1 -> 32 words: 0x1000..0x1013, w20=0x80000000,
//    w21..30=0, w31=0x00000280; blk_last at w15,w31; out_last at w31; done next cycle.
//  2 L=13 -> 16 words: w13=0x80000000, w14=0, w15=0x000001A0; one block only.
//  3 L=14 -> 32 words: w14=0x80000000, w15..30=0, w31=0x000001C0.
//  4 L=0 -> 16 words: w0=0x80000000, rest 0, w15=0; no mem reads issued (mem_addr unchanged).
//  5 Test 1 with random out_ready -> identical sequence; out_word stable while valid & !ready.
//  6 reset after 10 transfers -> out_valid=0, busy=0 next cycle; restart reproduces test 1;
//    start mid-stream ignored; msg_len=MAX_WORDS+1 -> len_err pulse, busy stays 0.

Source files
------------

// File: rtl/sha256_msg_padder.sv
// Fetches an L-word message from 1-cycle-latency memory and streams the SHA-256 padded
// message (data, 0x80000000, zero fill, 64-bit bit length) one word per handshake.
module sha256_msg_padder #(
    parameter int unsigned MAX_WORDS = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] message_addr,
    input  logic [15:0] msg_len,
    output logic        mem_clk,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    input  logic [31:0] mem_read_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_word,
    output logic        out_blk_last,
    output logic        out_last,
    output logic        busy,
    output logic        done,
    output logic        len_err
);

    localparam int unsigned AW = 16;
    localparam int unsigned LW = 16;
    localparam int unsigned DW = 32;
    localparam int unsigned IW = 17;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_SEND,
        S_PAD,
        S_DONE
    } state_t;

    state_t        state, state_nxt;
    logic [AW-1:0] base_addr, base_addr_nxt;
    logic [LW-1:0] len, len_nxt;
    logic [IW-1:0] w, w_nxt;
    logic [AW-1:0] mem_addr_nxt;
    logic          out_valid_nxt, out_blk_last_nxt, out_last_nxt;
    logic [DW-1:0] out_word_nxt;
    logic          busy_nxt, done_nxt, len_err_nxt;

    logic [IW-1:0] t_last_c;
    logic [IW-1:0] w_inc_c;

    assign mem_clk = clk;
    assign mem_we  = 1'b0;

    // Index of the final stream word: 16*ceil((L+3)/16) - 1.
    assign t_last_c = IW'(((IW'(len) + IW'(18)) >> 4) << 4) - IW'(1);
    assign w_inc_c  = w + IW'(1);

    function automatic logic [DW-1:0] pad_word(input logic [IW-1:0] idx,
                                               input logic [LW-1:0] l,
                                               input logic [IW-1:0] tl);
        logic [63:0] bits;
        bits = {43'd0, l, 5'd0};
        if (idx == IW'(l))               pad_word = 32'h8000_0000;
        else if (idx == tl - IW'(1))     pad_word = bits[63:32];
        else if (idx == tl)              pad_word = bits[31:0];
        else                             pad_word = '0;
    endfunction

    // Next-state and next-output logic.
    always_comb begin
        state_nxt        = state;
        base_addr_nxt    = base_addr;
        len_nxt          = len;
        w_nxt            = w;
        mem_addr_nxt     = mem_addr;
        out_valid_nxt    = out_valid;
        out_word_nxt     = out_word;
        out_blk_last_nxt = out_blk_last;
        out_last_nxt     = out_last;
        done_nxt         = 1'b0;
        len_err_nxt      = 1'b0;

        case (state)
            S_IDLE: begin
                if (start) begin
                    if (32'(msg_len) > MAX_WORDS) begin
                        len_err_nxt = 1'b1;
                    end else begin
                        base_addr_nxt = message_addr;
                        len_nxt       = msg_len;
                        w_nxt         = '0;
                        if (msg_len == '0) begin
                            // Empty message: first word is the 0x80000000 marker, no reads.
                            state_nxt        = S_PAD;
                            out_valid_nxt    = 1'b1;
                            out_word_nxt     = 32'h8000_0000;
                            out_blk_last_nxt = 1'b0;
                            out_last_nxt     = 1'b0;
                        end else begin
                            state_nxt    = S_REQ;
                            mem_addr_nxt = message_addr;
                        end
                    end
                end
            end
            S_REQ: begin
                state_nxt = S_WAIT;
            end
            S_WAIT: begin
                state_nxt        = S_SEND;
                out_valid_nxt    = 1'b1;
                out_word_nxt     = mem_read_data;
                out_blk_last_nxt = (w[3:0] == 4'hf);
                out_last_nxt     = (w == t_last_c);
            end
            S_SEND: begin
                if (out_ready) begin
                    w_nxt = w_inc_c;
                    if (w_inc_c < IW'(len)) begin
                        state_nxt        = S_REQ;
                        mem_addr_nxt     = base_addr + AW'(w_inc_c);
                        out_valid_nxt    = 1'b0;
                        out_blk_last_nxt = 1'b0;
                        out_last_nxt     = 1'b0;
                    end else begin
                        state_nxt        = S_PAD;
                        out_word_nxt     = pad_word(w_inc_c, len, t_last_c);
                        out_blk_last_nxt = (w_inc_c[3:0] == 4'hf);
                        out_last_nxt     = (w_inc_c == t_last_c);
                    end
                end
            end
            S_PAD: begin
                if (out_ready) begin
                    if (w == t_last_c) begin
                        state_nxt        = S_DONE;
                        out_valid_nxt    = 1'b0;
                        out_blk_last_nxt = 1'b0;
                        out_last_nxt     = 1'b0;
                        done_nxt         = 1'b1;
                    end else begin
                        w_nxt            = w_inc_c;
                        out_word_nxt     = pad_word(w_inc_c, len, t_last_c);
                        out_blk_last_nxt = (w_inc_c[3:0] == 4'hf);
                        out_last_nxt     = (w_inc_c == t_last_c);
                    end
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt     = S_IDLE;
                out_valid_nxt = 1'b0;
            end
        endcase

        busy_nxt = (state_nxt != S_IDLE);
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            base_addr    <= '0;
            len          <= '0;
            w            <= '0;
            mem_addr     <= '0;
            out_valid    <= 1'b0;
            out_word     <= '0;
            out_blk_last <= 1'b0;
            out_last     <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            len_err      <= 1'b0;
        end else begin
            state        <= state_nxt;
            base_addr    <= base_addr_nxt;
            len          <= len_nxt;
            w            <= w_nxt;
            mem_addr     <= mem_addr_nxt;
            out_valid    <= out_valid_nxt;
            out_word     <= out_word_nxt;
            out_blk_last <= out_blk_last_nxt;
            out_last     <= out_last_nxt;
            busy         <= busy_nxt;
            done         <= done_nxt;
            len_err      <= len_err_nxt;
        end
    end

endmodule
